// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage issuing the data-memory access over a req/ack SRAM-like bus.
// Latency: 1 cycle for non-memory ops; at least 3 cycles in MEM for loads/stores (REQ, WAIT, DONE).
// Backpressure: holds the entry while the access is incomplete or WB stalls; ms_allow_in gates EXE.
//
// Ports: clk/reset (async active-low); es_to_ms_valid/ms_allow_in/es_ms_bus from EXE;
// ws_allow_in/ms_to_ws_valid/ms_ws_bus to WB; ms_fwd_bus to decode; data_sram_* memory bus.
// Optional macro MS_ALIGN_CHECK_EN: misaligned half/word accesses are suppressed, gr_we is
// killed, and the extra output ms_ale flags the entry.
module mem_access_stage #(
  parameter  int PC_W    = 32,
  parameter  int RA_W    = 5,
  localparam int ES_MS_W = PC_W + RA_W + 70,
  localparam int MS_WS_W = PC_W + RA_W + 33
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               es_to_ms_valid,
  output logic               ms_allow_in,
  input  logic [ES_MS_W-1:0] es_ms_bus,
  input  logic               ws_allow_in,
  output logic               ms_to_ws_valid,
  output logic [MS_WS_W-1:0] ms_ws_bus,
  output logic [RA_W+33:0]   ms_fwd_bus,
  output logic               data_sram_req,
  output logic               data_sram_wr,
  output logic [1:0]         data_sram_size,
  output logic [3:0]         data_sram_wstrb,
  output logic [31:0]        data_sram_addr,
  output logic [31:0]        data_sram_wdata,
  input  logic               data_sram_addr_ok,
  input  logic               data_sram_data_ok,
  input  logic [31:0]        data_sram_rdata
`ifdef MS_ALIGN_CHECK_EN
  , output logic             ms_ale
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // incoming EXE bus fields
  logic [PC_W-1:0] in_pc;
  logic            in_gr_we;
  logic [RA_W-1:0] in_dest;
  logic [31:0]     in_alu;
  logic            in_mem_en;
  logic            in_mem_we;
  logic            in_mem_sign;
  logic [1:0]      in_mem_size;
  logic [31:0]     in_st_data;

  assign {in_pc, in_gr_we, in_dest, in_alu, in_mem_en, in_mem_we,
          in_mem_sign, in_mem_size, in_st_data} = es_ms_bus;

  // latched entry
  state_t          state;
  logic            ms_valid;
  logic [PC_W-1:0] pc_r;
  logic            gr_we_r;
  logic [RA_W-1:0] dest_r;
  logic [31:0]     alu_r;
  logic            mem_en_r;
  logic            mem_we_r;
  logic            mem_sign_r;
  logic [1:0]      mem_size_r;
  logic [31:0]     st_data_r;
  logic [31:0]     rdata_r;
  logic            req_r;

  logic ms_ready_go;
  logic latch;
  logic gr_we_eff;
  logic load_pending;

  assign ms_ready_go    = !mem_en_r || (state == DONE);
  assign ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign latch          = es_to_ms_valid && ms_allow_in;

`ifdef MS_ALIGN_CHECK_EN
  logic in_mis;
  logic mis_r;
  // size 3 is checked as a word
  assign in_mis = (in_mem_size == 2'd1 && in_alu[0]) ||
                  (in_mem_size[1] && in_alu[1:0] != 2'b00);
  assign mis_r  = (mem_size_r == 2'd1 && alu_r[0]) ||
                  (mem_size_r[1] && alu_r[1:0] != 2'b00);
  assign ms_ale    = ms_valid && mis_r;
  assign gr_we_eff = gr_we_r && !mis_r;
`else
  assign gr_we_eff = gr_we_r;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ms_valid   <= 1'b0;
      req_r      <= 1'b0;
      pc_r       <= '0;
      gr_we_r    <= 1'b0;
      dest_r     <= '0;
      alu_r      <= '0;
      mem_en_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_sign_r <= 1'b0;
      mem_size_r <= 2'd0;
      st_data_r  <= '0;
      rdata_r    <= '0;
    end else begin
      if (ms_allow_in) begin
        ms_valid <= es_to_ms_valid;
      end
      if (latch) begin
        pc_r       <= in_pc;
        gr_we_r    <= in_gr_we;
        dest_r     <= in_dest;
        alu_r      <= in_alu;
        mem_en_r   <= in_mem_en;
        mem_we_r   <= in_mem_we;
        mem_sign_r <= in_mem_sign;
        mem_size_r <= in_mem_size;
        st_data_r  <= in_st_data;
      end
      case (state)
        IDLE, DONE: begin
          if (latch) begin
            if (in_mem_en) begin
`ifdef MS_ALIGN_CHECK_EN
              if (in_mis) begin
                state <= DONE;
              end else begin
                state <= REQ;
                req_r <= 1'b1;
              end
`else
              state <= REQ;
              req_r <= 1'b1;
`endif
            end else begin
              state <= IDLE;
            end
          end else if (ms_allow_in) begin
            // entry retired (or none present) with nothing new behind it
            state <= IDLE;
          end
        end
        REQ: begin
          if (data_sram_addr_ok) begin
            req_r <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // data_ok only counts here, so a stale response after reset is dropped
          if (data_sram_data_ok) begin
            if (!mem_we_r) begin
              rdata_r <= data_sram_rdata;
            end
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // store lane steering
  logic [1:0] off;
  assign off = alu_r[1:0];

  always_comb begin
    data_sram_wstrb = 4'hF;
    data_sram_wdata = st_data_r;
    case (mem_size_r)
      2'd0: begin
        data_sram_wstrb = 4'b0001 << off;
        data_sram_wdata = {4{st_data_r[7:0]}};
      end
      2'd1: begin
        data_sram_wstrb = 4'b0011 << off;
        data_sram_wdata = {2{st_data_r[15:0]}};
      end
      default: begin
        data_sram_wstrb = 4'hF;
        data_sram_wdata = st_data_r;
      end
    endcase
    if (!mem_we_r) begin
      data_sram_wstrb = 4'h0;
    end
  end

  assign data_sram_req  = req_r;
  assign data_sram_wr   = mem_we_r;
  assign data_sram_size = (mem_size_r == 2'd3) ? 2'd2 : mem_size_r;
  assign data_sram_addr = alu_r;

  // load extraction from the captured read data
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] final_result;

  always_comb begin
    ld_byte = rdata_r[{off, 3'b000} +: 8];
    ld_half = off[1] ? rdata_r[31:16] : rdata_r[15:0];
    case (mem_size_r)
      2'd0:    ld_data = {{24{mem_sign_r & ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = {{16{mem_sign_r & ld_half[15]}}, ld_half};
      default: ld_data = rdata_r;
    endcase
  end

  assign final_result = (mem_en_r && !mem_we_r) ? ld_data : alu_r;
  assign load_pending = ms_valid && mem_en_r && !mem_we_r && (state != DONE);

  assign ms_ws_bus  = {pc_r, gr_we_eff, dest_r, final_result};
  assign ms_fwd_bus = {gr_we_eff && ms_valid, load_pending, dest_r, final_result};

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed bench with a WB-side scoreboard and a memory responder that
// checks each bus request against an expected-request queue.
// Latency/backpressure: responder latency and ws_allow_in are set per vector.
module tb_mem_access_stage;

  localparam int PC_W = 32;
  localparam int RA_W = 5;

  logic         clk;
  logic         reset;
  logic         es_to_ms_valid;
  logic         ms_allow_in;
  logic [106:0] es_ms_bus;
  logic         ws_allow_in;
  logic         ms_to_ws_valid;
  logic [69:0]  ms_ws_bus;
  logic [38:0]  ms_fwd_bus;
  logic         data_sram_req;
  logic         data_sram_wr;
  logic [1:0]   data_sram_size;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
`ifdef MS_ALIGN_CHECK_EN
  logic         ms_ale;
`endif

  mem_access_stage #(.PC_W(PC_W), .RA_W(RA_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allow_in       (ms_allow_in),
    .es_ms_bus         (es_ms_bus),
    .ws_allow_in       (ws_allow_in),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_ws_bus         (ms_ws_bus),
    .ms_fwd_bus        (ms_fwd_bus),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
`ifdef MS_ALIGN_CHECK_EN
    , .ms_ale          (ms_ale)
`endif
  );

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req[$];
  logic [69:0] exp_bus[$];

  int errors = 0;
  int checks = 0;

  // responder controls
  int          addr_dly = 0;
  int          data_dly = 0;
  int          acnt = 0;
  int          dcnt = 0;
  bit          wait_data = 0;
  logic [31:0] mem_rdata = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lat(input int a, input int d);
    addr_dly = a;
    data_dly = d;
    acnt     = a;
  endtask

  // memory responder: acks requests after addr_dly cycles, answers after data_dly more
  initial begin
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      if (wait_data) begin
        if (dcnt == 0) begin
          data_sram_data_ok = 1'b1;
          data_sram_rdata   = mem_rdata;
          wait_data         = 0;
        end else begin
          dcnt--;
        end
      end else if (data_sram_req) begin
        if (exp_req.size() == 0) begin
          chk("unexpected_req", {1'b1, data_sram_addr}, 128'h0);
        end else begin
          chk("req_fields",
              {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata},
              exp_req[0]);
        end
        if (acnt == 0) begin
          data_sram_addr_ok = 1'b1;
          wait_data         = 1;
          dcnt              = data_dly;
          acnt              = addr_dly;
          if (exp_req.size() != 0) void'(exp_req.pop_front());
        end else begin
          acnt--;
        end
      end
    end
  end

  // WB-side monitor
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset && ms_to_ws_valid && ws_allow_in) begin
        if (exp_bus.size() == 0) begin
          chk("unexpected_retire", {58'h0, ms_ws_bus}, 128'h0);
        end else begin
          chk("ms_ws_bus", {58'h0, ms_ws_bus}, {58'h0, exp_bus[0]});
          void'(exp_bus.pop_front());
        end
      end
    end
  end

  // returns at posedge+#1 right after the instruction was latched
  task automatic issue(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                       input logic [31:0] alu, input logic men, input logic we, input logic sgn,
                       input logic [1:0] sz, input logic [31:0] st, input logic [31:0] res,
                       input bit push_res, input logic [3:0] ewstrb, input logic [31:0] ewdata);
    bit ok = 0;
    req_t r;
    if (push_res) exp_bus.push_back({pc, gr_we, dest, res});
    if (men) begin
      r.wr = we; r.size = (sz == 2'd3) ? 2'd2 : sz; r.wstrb = ewstrb;
      r.addr = alu; r.wdata = ewdata;
      exp_req.push_back(r);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      es_ms_bus      = {pc, gr_we, dest, alu, men, we, sgn, sz, st};
      es_to_ms_valid = 1'b1;
      #1;
      if (ms_allow_in) begin ok = 1; break; end
    end
    if (!ok) chk("issue_timeout", 128'h0, 128'h1);
    @(posedge clk);
    #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (ms_to_ws_valid) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!ms_to_ws_valid) chk("valid_timeout", 128'h0, 128'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int bad;
    reset          = 1'b0;
    es_to_ms_valid = 1'b0;
    es_ms_bus      = '0;
    ws_allow_in    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_allow_in", {127'h0, ms_allow_in}, 128'h1);
    chk("rst_valid", {127'h0, ms_to_ws_valid}, 128'h0);
    chk("rst_req", {127'h0, data_sram_req}, 128'h0);
    chk("rst_ws_bus", {58'h0, ms_ws_bus}, 128'h0);
    chk("rst_fwd", {89'h0, ms_fwd_bus}, 128'h0);
    chk("rst_sram", {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata}, 128'h0);
    @(negedge clk);
    reset = 1'b1;

    // non-memory op: valid the cycle after latch, no request
    issue(32'h1C000000, 1, 5'd3, 32'h12345678, 0, 0, 0, 2'd0, 32'h0, 32'h12345678, 1, 4'h0, 32'h0);
    chk("nonmem_valid", {127'h0, ms_to_ws_valid}, 128'h1);
    chk("nonmem_fwd", {89'h0, ms_fwd_bus}, {89'h0, 1'b1, 1'b0, 5'd3, 32'h12345678});

    // signed byte load, immediate responder: valid in the third cycle in MEM
    set_lat(0, 0);
    mem_rdata = 32'h80FF7F01;
    issue(32'h1C000004, 1, 5'd5, 32'h00001002, 1, 0, 1, 2'd0, 32'h0, 32'hFFFFFFFF, 1, 4'h0, 32'h0);
    chk("lb_cyc1", {126'h0, ms_to_ws_valid, ms_fwd_bus[37]}, 128'h1);
    @(posedge clk); #1;
    chk("lb_cyc2", {126'h0, ms_to_ws_valid, ms_fwd_bus[37]}, 128'h1);
    @(posedge clk); #1;
    chk("lb_cyc3", {94'h0, ms_to_ws_valid, ms_fwd_bus[37], ms_fwd_bus[31:0]}, {94'h0, 2'b10, 32'hFFFFFFFF});

    // unsigned byte load, back-to-back
    issue(32'h1C000008, 1, 5'd6, 32'h00001002, 1, 0, 0, 2'd0, 32'h0, 32'h000000FF, 1, 4'h0, 32'h0);
    wait_valid(cyc);
    chk("lbu_latency", cyc, 2);

    // half store at offset 2
    issue(32'h1C00000C, 0, 5'd0, 32'h00002002, 1, 1, 0, 2'd1, 32'hAAAA1234, 32'h00002002, 1, 4'b1100, 32'h12341234);
    wait_valid(cyc);
    // byte store at offset 1
    issue(32'h1C000010, 0, 5'd0, 32'h00006001, 1, 1, 0, 2'd0, 32'h000000A5, 32'h00006001, 1, 4'b0010, 32'hA5A5A5A5);
    wait_valid(cyc);
    // size 3 store behaves as a word
    issue(32'h1C000014, 0, 5'd0, 32'h00007000, 1, 1, 0, 2'd3, 32'hCAFEF00D, 32'h00007000, 1, 4'hF, 32'hCAFEF00D);
    wait_valid(cyc);
`ifndef MS_ALIGN_CHECK_EN
    // signed half load, offset 3: upper half selected, off[0] ignored
    issue(32'h1C000018, 1, 5'd7, 32'h00005003, 1, 0, 1, 2'd1, 32'h0, 32'hFFFF80FF, 1, 4'h0, 32'h0);
    wait_valid(cyc);
`endif

    // variable latency: addr_ok after 4 cycles, data_ok 6 cycles later
    @(posedge clk); #1;
    set_lat(4, 6);
    mem_rdata = 32'hDEADBEEF;
    issue(32'h1C00001C, 1, 5'd9, 32'h00003000, 1, 0, 0, 2'd2, 32'h0, 32'hDEADBEEF, 1, 4'h0, 32'h0);
    cyc = 0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (ms_allow_in !== 1'b0 || ms_fwd_bus[37] !== 1'b1) bad++;
      @(posedge clk); #1;
      cyc++;
      if (ms_to_ws_valid) break;
    end
    chk("varlat_stall", bad, 0);
    chk("varlat_cycles", cyc, 12);
    set_lat(0, 0);

    // WB stall in DONE for 5 cycles
    @(posedge clk); #1;
    ws_allow_in = 1'b0;
    mem_rdata = 32'h01234567;
    issue(32'h1C000020, 1, 5'd10, 32'h00004000, 1, 0, 0, 2'd2, 32'h0, 32'h01234567, 1, 4'h0, 32'h0);
    wait_valid(cyc);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ms_ws_bus !== {32'h1C000020, 1'b1, 5'd10, 32'h01234567} ||
          data_sram_req !== 1'b0 || ms_to_ws_valid !== 1'b1) bad++;
    end
    chk("wb_stall_hold", bad, 0);
    ws_allow_in = 1'b1;
    @(posedge clk); #1;
    chk("wb_stall_retire", {126'h0, ms_to_ws_valid, ms_allow_in}, 128'h1);

    // reset while waiting for data_ok; the late data_ok must be ignored
    set_lat(0, 5);
    mem_rdata = 32'h55AA55AA;
    issue(32'h1C000024, 1, 5'd11, 32'h00008000, 1, 0, 0, 2'd2, 32'h0, 32'h0, 0, 4'h0, 32'h0);
    @(posedge clk); #1;
    chk("wait_req_low", {127'h0, data_sram_req}, 128'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_state", {125'h0, ms_to_ws_valid, ms_allow_in, ms_fwd_bus[37]}, 128'h2);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ms_to_ws_valid !== 1'b0 || data_sram_req !== 1'b0 || ms_allow_in !== 1'b1) bad++;
    end
    chk("midrst_ignore", bad, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("bus_queue_empty", exp_bus.size(), 0);
    chk("req_queue_empty", exp_req.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
